// File: rtl/irrigation_zone_scheduler_pkg.sv
// Shared types and helpers for the multi-bed irrigation scheduler.
package irrigation_pkg;

  typedef enum logic [1:0] {IDLE, RUN, GAP, ALARM} state_e;
  typedef enum logic {SPRINKLER, DRIPPER} mode_e;

  // A tank level pattern is physically possible only if the marks are filled bottom-up.
  function automatic logic level_consistent(input logic low, input logic mid, input logic high);
    return ~((mid & ~low) | (high & ~mid));
  endfunction

endpackage

// File: rtl/irrigation_zone_scheduler_level_monitor.sv
// Tank supervision: level-sensor debounce, hysteretic fill valve with timeout, latched alarm.
module level_monitor
  import irrigation_pkg::*;
#(
  parameter int DEBOUNCE     = 4,
  parameter int FILL_TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic low_water_level,
  input  logic mid_water_level,
  input  logic high_water_level,
  input  logic alarm_clear,
  output logic alarm,
  output logic alarm_next,
  output logic fill_valve
);

  localparam int DW = $clog2(DEBOUNCE + 1);
  localparam int FW = $clog2(FILL_TIMEOUT + 1);
  localparam logic [DW-1:0] DEB_MAX  = DW'(DEBOUNCE);
  localparam logic [FW-1:0] FILL_MAX = FW'(FILL_TIMEOUT);

  logic [DW-1:0] deb_cnt_q, deb_cnt_d;
  logic [FW-1:0] fill_cnt_q, fill_cnt_d;
  logic          alarm_q, alarm_d;
  logic          fill_q, fill_d;
  logic          consistent;

  always_comb begin
    consistent = level_consistent(low_water_level, mid_water_level, high_water_level);

    deb_cnt_d = '0;
    if (!consistent)
      deb_cnt_d = (deb_cnt_q == DEB_MAX) ? deb_cnt_q : deb_cnt_q + DW'(1);

    fill_cnt_d = '0;
    if (fill_q)
      fill_cnt_d = (fill_cnt_q == FILL_MAX) ? fill_cnt_q : fill_cnt_q + FW'(1);

    // Setting wins over a simultaneous clear pulse.
    alarm_d = alarm_q;
    if (alarm_clear && consistent)
      alarm_d = 1'b0;
    if ((deb_cnt_d == DEB_MAX) || (fill_cnt_d == FILL_MAX))
      alarm_d = 1'b1;

    fill_d = fill_q;
    if (alarm_d || high_water_level)
      fill_d = 1'b0;
    else if (!mid_water_level)
      fill_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      deb_cnt_q  <= '0;
      fill_cnt_q <= '0;
      alarm_q    <= 1'b0;
      fill_q     <= 1'b0;
    end else begin
      deb_cnt_q  <= deb_cnt_d;
      fill_cnt_q <= fill_cnt_d;
      alarm_q    <= alarm_d;
      fill_q     <= fill_d;
    end
  end

  assign alarm      = alarm_q;
  assign alarm_next = alarm_d;
  assign fill_valve = fill_q;

endmodule

// File: rtl/irrigation_zone_scheduler.sv
// Round-robin irrigation of ZONES beds from a shared tank, one bed at a time,
// with per-bed sprinkler/dripper selection and bounded run length.
module irrigation_zone_scheduler
  import irrigation_pkg::*;
#(
  parameter int ZONES        = 4,
  parameter int DEBOUNCE     = 4,
  parameter int RUN_CYCLES   = 16,
  parameter int FILL_TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     low_water_level,
  input  logic                     mid_water_level,
  input  logic                     high_water_level,
  input  logic [ZONES-1:0]         earth_humidity,
  input  logic [ZONES-1:0]         air_humidity,
  input  logic                     low_temperature,
  input  logic                     alarm_clear,
  output logic                     water_supply_valvule,
  output logic                     alarm,
  output logic                     splinker_bomb,
  output logic                     dripper_valvule,
  output logic [ZONES-1:0]         zone_valve,
  output logic [$clog2(ZONES)-1:0] active_zone
);

  localparam int ZW = $clog2(ZONES);
  localparam int RW = $clog2(RUN_CYCLES);
  localparam logic [ZW-1:0] ZONE_LAST = ZW'(ZONES - 1);
  localparam logic [RW-1:0] RUN_LAST  = RW'(RUN_CYCLES - 1);

  state_e           state_q, state_d;
  mode_e            mode_q, mode_d;
  logic [ZW-1:0]    zone_q, zone_d;
  logic [RW-1:0]    run_cnt_q, run_cnt_d;
  logic [ZONES-1:0] zone_valve_q, zone_valve_d;
  logic             spr_q, spr_d;
  logic             drip_q, drip_d;
  logic             alarm_next;
  logic             cand_spr, cand_level_ok, run_level_ok;

  level_monitor #(
    .DEBOUNCE     (DEBOUNCE),
    .FILL_TIMEOUT (FILL_TIMEOUT)
  ) u_level_monitor (
    .clk              (clk),
    .rst              (rst),
    .low_water_level  (low_water_level),
    .mid_water_level  (mid_water_level),
    .high_water_level (high_water_level),
    .alarm_clear      (alarm_clear),
    .alarm            (alarm),
    .alarm_next       (alarm_next),
    .fill_valve       (water_supply_valvule)
  );

  function automatic logic [ZW-1:0] zone_inc(input logic [ZW-1:0] z);
    return (z == ZONE_LAST) ? '0 : z + ZW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      mode_q       <= SPRINKLER;
      zone_q       <= '0;
      run_cnt_q    <= '0;
      zone_valve_q <= '0;
      spr_q        <= 1'b0;
      drip_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      zone_q       <= zone_d;
      run_cnt_q    <= run_cnt_d;
      zone_valve_q <= zone_valve_d;
      spr_q        <= spr_d;
      drip_q       <= drip_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    zone_d    = zone_q;
    run_cnt_d = run_cnt_q;

    cand_spr      = ~air_humidity[zone_q] & ~low_temperature;
    cand_level_ok = cand_spr ? mid_water_level : low_water_level;
    run_level_ok  = (mode_q == SPRINKLER) ? mid_water_level : low_water_level;

    // A newly set or still-held alarm pre-empts every scheduler decision.
    if (alarm_next) begin
      state_d = ALARM;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (!earth_humidity[zone_q] && cand_level_ok) begin
            state_d   = RUN;
            mode_d    = cand_spr ? SPRINKLER : DRIPPER;
            run_cnt_d = '0;
          end else begin
            zone_d = zone_inc(zone_q);
          end
        end
        RUN: begin
          if ((run_cnt_q == RUN_LAST) || earth_humidity[zone_q] || !run_level_ok)
            state_d = GAP;
          else
            run_cnt_d = run_cnt_q + RW'(1);
        end
        GAP: begin
          state_d = IDLE;
          zone_d  = zone_inc(zone_q);
        end
        ALARM: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs are registered from the next state so they change on the deciding edge.
  always_comb begin
    zone_valve_d = '0;
    spr_d        = 1'b0;
    drip_d       = 1'b0;
    if (state_d == RUN) begin
      zone_valve_d[zone_d] = 1'b1;
      spr_d                = (mode_d == SPRINKLER);
      drip_d               = (mode_d == DRIPPER);
    end
  end

  assign zone_valve      = zone_valve_q;
  assign splinker_bomb   = spr_q;
  assign dripper_valvule = drip_q;
  assign active_zone     = zone_q;

endmodule

// File: tb/tb_irrigation_zone_scheduler.sv
// Directed and randomized checks of irrigation_zone_scheduler against a cycle-level behavioural model.
module tb_irrigation_zone_scheduler;

  localparam int ZONES        = 4;
  localparam int DEBOUNCE     = 4;
  localparam int RUN_CYCLES   = 16;
  localparam int FILL_TIMEOUT = 64;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             low_water_level = 1'b1;
  logic             mid_water_level = 1'b1;
  logic             high_water_level = 1'b1;
  logic [ZONES-1:0] earth_humidity = '1;
  logic [ZONES-1:0] air_humidity = '0;
  logic             low_temperature = 1'b0;
  logic             alarm_clear = 1'b0;
  logic             water_supply_valvule;
  logic             alarm;
  logic             splinker_bomb;
  logic             dripper_valvule;
  logic [ZONES-1:0] zone_valve;
  logic [1:0]       active_zone;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  irrigation_zone_scheduler #(
    .ZONES        (ZONES),
    .DEBOUNCE     (DEBOUNCE),
    .RUN_CYCLES   (RUN_CYCLES),
    .FILL_TIMEOUT (FILL_TIMEOUT)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .low_water_level      (low_water_level),
    .mid_water_level      (mid_water_level),
    .high_water_level     (high_water_level),
    .earth_humidity       (earth_humidity),
    .air_humidity         (air_humidity),
    .low_temperature      (low_temperature),
    .alarm_clear          (alarm_clear),
    .water_supply_valvule (water_supply_valvule),
    .alarm                (alarm),
    .splinker_bomb        (splinker_bomb),
    .dripper_valvule      (dripper_valvule),
    .zone_valve           (zone_valve),
    .active_zone          (active_zone)
  );

  always #5 clk = ~clk;

  // Behavioural reference: counts of consecutive bad samples and open cycles,
  // plus a bed pointer and a "cycles already watered" tally for the current bed.
  int m_incons, m_open, m_ptr, m_served;
  bit m_alarm, m_fill, m_halt, m_run, m_gap, m_spr;

  always @(posedge clk) begin : model
    bit incons, want_spr, lvl_ok;
    if (rst) begin
      m_incons = 0; m_open = 0; m_ptr = 0; m_served = 0;
      m_alarm = 0; m_fill = 0; m_halt = 0; m_run = 0; m_gap = 0; m_spr = 0;
    end else begin
      incons   = (mid_water_level && !low_water_level) || (high_water_level && !mid_water_level);
      m_incons = incons ? m_incons + 1 : 0;
      m_open   = m_fill ? m_open + 1 : 0;
      if (alarm_clear && !incons) m_alarm = 0;
      if (m_incons >= DEBOUNCE || m_open >= FILL_TIMEOUT) m_alarm = 1;
      if (m_alarm || high_water_level) m_fill = 0;
      else if (!mid_water_level) m_fill = 1;

      if (m_alarm) begin
        m_halt = 1; m_run = 0; m_gap = 0;
      end else if (m_halt) begin
        m_halt = 0;
      end else if (m_gap) begin
        m_gap = 0;
        m_ptr = (m_ptr + 1) % ZONES;
      end else if (m_run) begin
        m_served = m_served + 1;
        lvl_ok = m_spr ? mid_water_level : low_water_level;
        if (m_served >= RUN_CYCLES || earth_humidity[m_ptr] || !lvl_ok) begin
          m_run = 0; m_gap = 1;
        end
      end else begin
        want_spr = !air_humidity[m_ptr] && !low_temperature;
        lvl_ok   = want_spr ? mid_water_level : low_water_level;
        if (!earth_humidity[m_ptr] && lvl_ok) begin
          m_run = 1; m_spr = want_spr; m_served = 0;
        end else begin
          m_ptr = (m_ptr + 1) % ZONES;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_model(input string tag);
    logic [31:0] e_zv;
    e_zv = m_run ? (32'd1 << m_ptr) : 32'd0;
    chk({tag, ".zone_valve"}, 32'(zone_valve), e_zv);
    chk({tag, ".sprinkler"}, 32'(splinker_bomb), 32'(m_run && m_spr));
    chk({tag, ".dripper"}, 32'(dripper_valvule), 32'(m_run && !m_spr));
    chk({tag, ".fill"}, 32'(water_supply_valvule), 32'(m_fill));
    chk({tag, ".alarm"}, 32'(alarm), 32'(m_alarm));
    chk({tag, ".active_zone"}, 32'(active_zone), 32'(m_ptr));
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    #1;
    check_model(tag);
  endtask

  task automatic set_levels(input logic l, input logic m, input logic h);
    low_water_level  = l;
    mid_water_level  = m;
    high_water_level = h;
  endtask

  initial begin
    int found, opened, saved_zone, r, k;

    // Reset with a full tank and all beds wet.
    step("reset");
    step("reset");
    chk("reset.zone_valve", 32'(zone_valve), 0);
    chk("reset.sprinkler", 32'(splinker_bomb), 0);
    chk("reset.dripper", 32'(dripper_valvule), 0);
    chk("reset.fill", 32'(water_supply_valvule), 0);
    chk("reset.alarm", 32'(alarm), 0);
    chk("reset.active_zone", 32'(active_zone), 0);
    rst = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      step("rr");
      chk("rr.active_zone", 32'(active_zone), 32'(i % ZONES));
    end

    // Sprinkler full run on bed 2.
    set_levels(1, 1, 0);
    earth_humidity = 4'b1011;
    air_humidity = '0;
    low_temperature = 1'b0;
    found = 0;
    for (int i = 0; i < 8 && found == 0; i++) begin
      step("spr_wait");
      if (zone_valve != 0) found = 1;
    end
    chk("spr.started", 32'(found), 1);
    chk("spr.zone", 32'(zone_valve), 32'h4);
    chk("spr.pump", 32'(splinker_bomb), 1);
    chk("spr.drip", 32'(dripper_valvule), 0);
    for (int i = 0; i < RUN_CYCLES - 1; i++) begin
      step("spr_run");
      chk("spr.zone_hold", 32'(zone_valve), 32'h4);
      chk("spr.pump_hold", 32'(splinker_bomb), 1);
    end
    step("spr_gap");
    chk("spr.gap_zone", 32'(zone_valve), 0);
    chk("spr.gap_pump", 32'(splinker_bomb), 0);
    earth_humidity = '1;
    step("spr_after");
    chk("spr.next_zone", 32'(active_zone), 3);

    // Dripper on bed 0 with only the low mark wet, stopped early by soil moisture.
    set_levels(1, 0, 0);
    low_temperature = 1'b1;
    earth_humidity = 4'b1110;
    found = 0;
    for (int i = 0; i < 8 && found == 0; i++) begin
      step("drip_wait");
      if (zone_valve != 0) found = 1;
    end
    chk("drip.started", 32'(found), 1);
    chk("drip.zone", 32'(zone_valve), 32'h1);
    chk("drip.valve", 32'(dripper_valvule), 1);
    chk("drip.pump", 32'(splinker_bomb), 0);
    chk("drip.fill_open", 32'(water_supply_valvule), 1);
    repeat (4) begin
      step("drip_run");
      chk("drip.valve_hold", 32'(dripper_valvule), 1);
    end
    earth_humidity = '1;
    step("drip_stop");
    chk("drip.stop_valve", 32'(dripper_valvule), 0);
    chk("drip.stop_zone", 32'(zone_valve), 0);

    // Fill hysteresis: stays open through mid, closes at high.
    low_temperature = 1'b0;
    set_levels(1, 1, 0);
    step("fill_mid");
    step("fill_mid");
    chk("fill.mid_open", 32'(water_supply_valvule), 1);
    set_levels(1, 1, 1);
    step("fill_high");
    chk("fill.high_closed", 32'(water_supply_valvule), 0);

    // Debounce of an impossible level pattern.
    set_levels(1, 0, 1);
    repeat (DEBOUNCE - 1) step("deb_short");
    chk("deb.no_alarm", 32'(alarm), 0);
    step("deb_long");
    chk("deb.alarm", 32'(alarm), 1);
    chk("deb.fill_off", 32'(water_supply_valvule), 0);
    chk("deb.zone_off", 32'(zone_valve), 0);
    saved_zone = int'(active_zone);
    alarm_clear = 1'b1;
    step("deb_clear_ignored");
    alarm_clear = 1'b0;
    chk("deb.clear_ignored", 32'(alarm), 1);
    set_levels(1, 1, 1);
    step("deb_fixed");
    alarm_clear = 1'b1;
    step("deb_clear");
    alarm_clear = 1'b0;
    chk("deb.cleared", 32'(alarm), 0);
    chk("deb.zone_kept", 32'(active_zone), 32'(saved_zone));

    // Fill timeout with the tank stuck empty.
    set_levels(0, 0, 0);
    opened = 0;
    found = 0;
    for (int i = 0; i < FILL_TIMEOUT + 16 && found == 0; i++) begin
      step("timeout_wait");
      if (alarm) found = 1;
      else if (water_supply_valvule) opened++;
    end
    chk("timeout.alarm", 32'(found), 1);
    chk("timeout.open_cycles", 32'(opened), FILL_TIMEOUT);
    chk("timeout.fill_off", 32'(water_supply_valvule), 0);
    set_levels(1, 1, 1);
    alarm_clear = 1'b1;
    step("timeout_clear");
    alarm_clear = 1'b0;
    chk("timeout.cleared", 32'(alarm), 0);

    // Reset in the middle of a dripper run on bed 1.
    earth_humidity = 4'b1101;
    air_humidity = '1;
    found = 0;
    for (int i = 0; i < 8 && found == 0; i++) begin
      step("rst_wait");
      if (zone_valve != 0) found = 1;
    end
    chk("rstrun.started", 32'(found), 1);
    chk("rstrun.zone", 32'(zone_valve), 32'h2);
    step("rstrun_run");
    step("rstrun_run");
    rst = 1'b1;
    step("rstrun_reset");
    chk("rstrun.zone_off", 32'(zone_valve), 0);
    chk("rstrun.drip_off", 32'(dripper_valvule), 0);
    chk("rstrun.active_zone", 32'(active_zone), 0);
    rst = 1'b0;
    earth_humidity = '1;
    air_humidity = '0;
    step("post_reset");

    // Randomized operation against the model.
    for (int c = 0; c < 600; c++) begin
      if (c % 5 == 0) begin
        r = int'($urandom_range(0, 15));
        if (r < 13) begin
          k = r % 4;
          set_levels(k >= 1, k >= 2, k >= 3);
        end else begin
          set_levels(1'($urandom), 1'($urandom), 1'($urandom));
        end
      end
      if (c % 8 == 0) begin
        earth_humidity  = 4'($urandom) | 4'($urandom);
        air_humidity    = 4'($urandom);
        low_temperature = 1'($urandom);
      end
      alarm_clear = ($urandom_range(0, 7) == 0);
      step("rand");
    end
    alarm_clear = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
